sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single-ported synchronous SRAM between the instruction-fetch port (IF) and the data port (EX/MEM) of the five-stage pipeline. It grants at most one access per cycle, steers the shared SRAM address and write lines, and routes the one-cycle-later read data back to the port that issued the read. It raises stall requests toward the pipeline controller when a requester loses arbitration. A starvation counter guarantees forward progress for instruction fetch under back-to-back data traffic.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles IF may lose to data before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard any outstanding IF read response (branch/exception redirect)
- inst_req  in  1  IF requests a read
- inst_addr  in  32  IF word address
- inst_gnt  out  1  IF access issued this cycle
- inst_rvalid  out  1  inst_rdata valid this cycle
- inst_rdata  out  32  read data to IF
- data_req  in  1  data port requests an access
- data_we  in  4  byte write enables; 4'b0000 = read
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_gnt  out  1  data access issued this cycle
- data_rvalid  out  1  data_rdata valid this cycle
- data_rdata  out  32  read data to MEM
- sram_en  out  1  SRAM enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after a read enable
- stallreq_if  out  1  inst_req & ~inst_gnt
- stallreq_mem  out  1  data_req & ~data_gnt

## Operation
- Arbitration (combinational, same cycle): data wins by default. IF wins when data_req=0, or when starve_cnt == STARVE_LIMIT and inst_req=1.
- Exactly one of inst_gnt/data_gnt is high when any request is present; both are low when none is present.
- Granted port drives sram_addr/sram_wen/sram_wdata; sram_en = inst_gnt | data_gnt. IF grant forces sram_wen=0, sram_wdata=0. With no grant, sram_en=0, sram_wen=0, and sram_addr holds the last granted address.
- starve_cnt (4 bits): increments when inst_req & data_gnt; clears when inst_gnt or when inst_req=0; never exceeds STARVE_LIMIT.
- Response owner register owner_r (states IDLE, INST, DATA): next = INST on an IF grant, DATA on a data read grant (data_we=0), IDLE otherwise, including data writes.
- In the cycle after the grant: owner_r=INST gives inst_rvalid=1 and inst_rdata=sram_rdata; owner_r=DATA gives data_rvalid=1 and data_rdata=sram_rdata. The non-owner rdata output is 0.
- flush: when flush=1 and owner_r=INST, inst_rvalid is forced to 0 that cycle. When flush=1 coincides with an IF grant, the issued read is marked dead (owner_r <= IDLE), so its response is never delivered. flush does not affect data traffic.
- Writes produce no rvalid; a write followed immediately by a read of the same address returns the written data, because SRAM write-first is a system property.

## Timing
- Grant latency 0 cycles; read response latency exactly 1 cycle after the grant; throughput one access per cycle.
- Reset: owner_r=IDLE, starve_cnt=0, sram_addr register=0. All outputs 0 during and immediately after reset: gnts, rvalids, rdata, sram_en, sram_wen, stallreqs.
- Reset asserted while a read is outstanding: the response is dropped; no rvalid appears in the cycle after reset deasserts.
- Simultaneous inst_req and data_req with starve_cnt < STARVE_LIMIT: data granted, stallreq_if=1, starve_cnt+1.
- Back-to-back grants to alternating owners: each response goes only to its own owner, with no bubble.

## Test plan
- Reset: hold rst 2 cycles with both reqs high -> all outputs 0; first cycle after release, data_gnt=1, no rvalid.
- IF-only read at 0x0000_0040 with sram_rdata=0x2402_0005 next cycle -> inst_gnt=1 at cycle N; inst_rvalid=1, inst_rdata=0x2402_0005 at N+1; data_rvalid=0.
- Data store data_we=4'b0011, addr 0x100, wdata 0xDEAD_BEEF -> sram_en=1, sram_wen=4'b0011, sram_wdata=0xDEAD_BEEF; no rvalid at N+1.
- Starvation, STARVE_LIMIT=4: both reqs held high -> data granted 4 cycles (stallreq_if=1), IF granted cycle 5, starve_cnt returns to 0, pattern repeats.
- Flush: IF grant at N with flush=1 at N+1 -> inst_rvalid=0 at N+1. Also IF grant with flush=1 in the same cycle -> no inst_rvalid at N+1.
- Alternation: data read 0x200 at N, IF read 0x44 at N+1 -> data_rvalid at N+1 with the 0x200 data; inst_rvalid at N+2 with the 0x44 data; never both rvalids in one cycle.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - signal bundle between the pipeline ports, the SRAM and the arbiter
//
// Groups the IF port, the data (EX/MEM) port, the SRAM macro pins and the
// stall requests to the pipeline controller.
//   slave  : the arbiter side (consumes requests, produces grants/responses)
//   master : the requester/SRAM side (produces requests and SRAM read data)
interface sram_port_arbiter_if;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;

  modport slave (
    input  flush, inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, sram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
           sram_en, sram_wen, sram_addr, sram_wdata, stallreq_if, stallreq_mem
  );

  modport master (
    output flush, inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, sram_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
           sram_en, sram_wen, sram_addr, sram_wdata, stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - single-ported SRAM arbiter between instruction fetch and data port
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : sram_port_arbiter_if.slave
//          IF port    flush, inst_req, inst_addr -> inst_gnt, inst_rvalid, inst_rdata
//          data port  data_req, data_we, data_addr, data_wdata -> data_gnt, data_rvalid, data_rdata
//          SRAM       sram_en, sram_wen, sram_addr, sram_wdata <- sram_rdata
//          stalls     stallreq_if, stallreq_mem
// Parameter:
//   STARVE_LIMIT : consecutive lost cycles after which IF is forced to win (1..15)
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  sram_port_arbiter_if.slave bus
);

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic [1:0]  owner_r;
  logic [31:0] addr_r;
  logic        if_win;
  logic        inst_gnt;
  logic        data_gnt;

  // Data wins unless it is idle or IF has been starved for LIMIT cycles.
  // Grants are held off during reset so nothing reaches the SRAM.
  always_comb begin
    if_win   = bus.inst_req & (~bus.data_req | (starve_cnt == LIMIT));
    inst_gnt = ~rst & if_win;
    data_gnt = ~rst & bus.data_req & ~if_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (inst_gnt | ~bus.inst_req) begin
      starve_cnt <= 4'd0;
    end else if (data_gnt && starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // A read issued together with flush is already stale, so its response is
  // never tagged for IF. Writes never produce a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= OWN_IDLE;
    end else if (inst_gnt) begin
      owner_r <= bus.flush ? OWN_IDLE : OWN_INST;
    end else if (data_gnt && bus.data_we == 4'b0000) begin
      owner_r <= OWN_DATA;
    end else begin
      owner_r <= OWN_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r <= 32'd0;
    end else if (inst_gnt) begin
      addr_r <= bus.inst_addr;
    end else if (data_gnt) begin
      addr_r <= bus.data_addr;
    end
  end

  always_comb begin
    bus.inst_gnt     = inst_gnt;
    bus.data_gnt     = data_gnt;
    bus.stallreq_if  = ~rst & bus.inst_req & ~inst_gnt;
    bus.stallreq_mem = ~rst & bus.data_req & ~data_gnt;
    bus.sram_en      = inst_gnt | data_gnt;
    bus.sram_wen     = 4'b0000;
    bus.sram_wdata   = 32'd0;
    bus.sram_addr    = addr_r;
    if (inst_gnt) begin
      bus.sram_addr = bus.inst_addr;
    end else if (data_gnt) begin
      bus.sram_addr  = bus.data_addr;
      bus.sram_wen   = bus.data_we;
      bus.sram_wdata = bus.data_wdata;
    end
  end

  // Responses land one cycle after the grant; only the owner sees data.
  always_comb begin
    bus.inst_rvalid = ~rst & (owner_r == OWN_INST) & ~bus.flush;
    bus.data_rvalid = ~rst & (owner_r == OWN_DATA);
    bus.inst_rdata  = bus.inst_rvalid ? bus.sram_rdata : 32'd0;
    bus.data_rdata  = bus.data_rvalid ? bus.sram_rdata : 32'd0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  sram_port_arbiter_if bus ();

  sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #2;
  endtask

  initial begin
    logic [7:0] flags;
    logic       exp_if;

    n_checks = 0;
    n_fails  = 0;

    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'h0000_0010;
    bus.data_req   = 1'b1;
    bus.data_we    = 4'b0000;
    bus.data_addr  = 32'h0000_0300;
    bus.data_wdata = 32'h1234_5678;
    bus.sram_rdata = 32'hFFFF_FFFF;

    // Reset held two cycles with both requests high.
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      settle();
      flags = {bus.inst_gnt, bus.data_gnt, bus.inst_rvalid, bus.data_rvalid,
               bus.sram_en, bus.stallreq_if, bus.stallreq_mem, 1'b0};
      chk("reset_flags", {24'd0, flags}, 32'd0);
      chk("reset_wen", {28'd0, bus.sram_wen}, 32'd0);
      chk("reset_rdata", bus.inst_rdata | bus.data_rdata, 32'd0);
    end
    chk("reset_addr", bus.sram_addr, 32'd0);

    // First cycle after release: data wins, no response yet.
    rst = 1'b0;
    settle();
    chk("post_rst_data_gnt", {31'd0, bus.data_gnt}, 32'd1);
    chk("post_rst_inst_gnt", {31'd0, bus.inst_gnt}, 32'd0);
    chk("post_rst_rvalids", {30'd0, bus.inst_rvalid, bus.data_rvalid}, 32'd0);
    chk("post_rst_stall_if", {31'd0, bus.stallreq_if}, 32'd1);
    chk("post_rst_addr", bus.sram_addr, 32'h0000_0300);

    // Data read response; address holds with no grant.
    next_cycle();
    bus.inst_req   = 1'b0;
    bus.data_req   = 1'b0;
    bus.sram_rdata = 32'h1111_2222;
    settle();
    chk("dread_rvalid", {31'd0, bus.data_rvalid}, 32'd1);
    chk("dread_rdata", bus.data_rdata, 32'h1111_2222);
    chk("dread_inst_rdata", bus.inst_rdata, 32'd0);
    chk("idle_en", {31'd0, bus.sram_en}, 32'd0);
    chk("idle_addr_hold", bus.sram_addr, 32'h0000_0300);

    // IF-only read at 0x40.
    next_cycle();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_0040;
    settle();
    chk("ifread_gnt", {31'd0, bus.inst_gnt}, 32'd1);
    chk("ifread_addr", bus.sram_addr, 32'h0000_0040);
    chk("ifread_wen", {28'd0, bus.sram_wen}, 32'd0);
    chk("ifread_stall", {31'd0, bus.stallreq_if}, 32'd0);

    next_cycle();
    bus.inst_req   = 1'b0;
    bus.sram_rdata = 32'h2402_0005;
    settle();
    chk("ifresp_rvalid", {31'd0, bus.inst_rvalid}, 32'd1);
    chk("ifresp_rdata", bus.inst_rdata, 32'h2402_0005);
    chk("ifresp_data_rvalid", {31'd0, bus.data_rvalid}, 32'd0);
    chk("ifresp_data_rdata", bus.data_rdata, 32'd0);

    // Partial store.
    next_cycle();
    bus.data_req   = 1'b1;
    bus.data_we    = 4'b0011;
    bus.data_addr  = 32'h0000_0100;
    bus.data_wdata = 32'hDEAD_BEEF;
    settle();
    chk("store_gnt", {31'd0, bus.data_gnt}, 32'd1);
    chk("store_en", {31'd0, bus.sram_en}, 32'd1);
    chk("store_wen", {28'd0, bus.sram_wen}, 32'h3);
    chk("store_wdata", bus.sram_wdata, 32'hDEAD_BEEF);
    chk("store_addr", bus.sram_addr, 32'h0000_0100);
    chk("store_stall_mem", {31'd0, bus.stallreq_mem}, 32'd0);

    next_cycle();
    bus.data_req   = 1'b0;
    bus.data_we    = 4'b0000;
    bus.sram_rdata = 32'h0000_5555;
    settle();
    chk("store_no_rvalid", {30'd0, bus.inst_rvalid, bus.data_rvalid}, 32'd0);

    // Starvation: both requests held, IF forced through every fifth cycle.
    next_cycle();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_0044;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_0200;
    for (int k = 0; k < 10; k++) begin
      settle();
      exp_if = (k % 5 == 4);
      chk($sformatf("starve_inst_gnt_%0d", k), {31'd0, bus.inst_gnt}, {31'd0, exp_if});
      chk($sformatf("starve_data_gnt_%0d", k), {31'd0, bus.data_gnt}, {31'd0, ~exp_if});
      chk($sformatf("starve_stall_if_%0d", k), {31'd0, bus.stallreq_if}, {31'd0, ~exp_if});
      if (k < 9) next_cycle();
    end

    // Last starvation cycle was an IF grant; flush kills its response.
    next_cycle();
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    bus.flush    = 1'b1;
    settle();
    chk("flush_next_rvalid", {31'd0, bus.inst_rvalid}, 32'd0);
    chk("flush_next_rdata", bus.inst_rdata, 32'd0);

    // Flush coinciding with the IF grant.
    next_cycle();
    bus.inst_req = 1'b1;
    settle();
    chk("flush_same_gnt", {31'd0, bus.inst_gnt}, 32'd1);
    next_cycle();
    bus.inst_req   = 1'b0;
    bus.flush      = 1'b0;
    bus.sram_rdata = 32'h0000_7777;
    settle();
    chk("flush_same_rvalid", {31'd0, bus.inst_rvalid}, 32'd0);

    // Alternating owners back-to-back.
    next_cycle();
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_0200;
    settle();
    chk("alt_data_gnt", {31'd0, bus.data_gnt}, 32'd1);
    next_cycle();
    bus.data_req   = 1'b0;
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'h0000_0044;
    bus.sram_rdata = 32'hAAAA_0200;
    settle();
    chk("alt_data_rvalid", {31'd0, bus.data_rvalid}, 32'd1);
    chk("alt_data_rdata", bus.data_rdata, 32'hAAAA_0200);
    chk("alt_inst_rvalid_n", {31'd0, bus.inst_rvalid}, 32'd0);
    chk("alt_inst_gnt", {31'd0, bus.inst_gnt}, 32'd1);
    chk("alt_inst_addr", bus.sram_addr, 32'h0000_0044);
    next_cycle();
    bus.inst_req   = 1'b0;
    bus.sram_rdata = 32'hBBBB_0044;
    settle();
    chk("alt_inst_rvalid", {31'd0, bus.inst_rvalid}, 32'd1);
    chk("alt_inst_rdata", bus.inst_rdata, 32'hBBBB_0044);
    chk("alt_data_rvalid_n", {31'd0, bus.data_rvalid}, 32'd0);

    // Reset while an IF read is outstanding drops the response.
    next_cycle();
    bus.inst_req = 1'b1;
    settle();
    chk("rstout_gnt", {31'd0, bus.inst_gnt}, 32'd1);
    next_cycle();
    rst          = 1'b1;
    bus.inst_req = 1'b0;
    settle();
    chk("rstout_during", {30'd0, bus.inst_rvalid, bus.data_rvalid}, 32'd0);
    next_cycle();
    rst = 1'b0;
    settle();
    chk("rstout_after", {30'd0, bus.inst_rvalid, bus.data_rvalid}, 32'd0);
    chk("rstout_addr", bus.sram_addr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
